// File: rtl/io_port_responder.sv
// Memory-mapped I/O slave for the MEM-stage data bus: output port registers,
// synchronized input ports, change-detect status, free-running timer with
// compare, and a level interrupt.
module io_port_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_W     = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  input  logic        io_re,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [31:0] io_read_data,
  output logic        io_rvalid,
  output logic        io_irq
);

  // Word offsets (io_addr[7:2])
  localparam logic [5:0] W_OUT0   = 6'h20;
  localparam logic [5:0] W_OUT1   = 6'h21;
  localparam logic [5:0] W_OUT2   = 6'h22;
  localparam logic [5:0] W_IN0    = 6'h30;
  localparam logic [5:0] W_IN1    = 6'h31;
  localparam logic [5:0] W_STATUS = 6'h32;
  localparam logic [5:0] W_TIMER  = 6'h33;
  localparam logic [5:0] W_CMP    = 6'h34;
  localparam logic [5:0] W_IRQ_EN = 6'h35;

  logic [5:0]         word;
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        sync0 [SYNC_STAGES];
  logic [31:0]        sync1 [SYNC_STAGES];
  logic [31:0]        in0_s;
  logic [31:0]        in1_s;
  logic [31:0]        prev0;
  logic [31:0]        prev1;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] cmp;
  logic [2:0]         irq_en;
  logic [2:0]         status;
  logic [2:0]         status_set;
  logic               status_clr;
  logic               timer_match;
  logic [31:0]        rd_mux;
  logic               unused_addr_bits;

  assign word             = io_addr[7:2];
  assign wr_en            = io_we & io_addr[7];
  assign rd_en            = io_re & io_addr[7];
  assign unused_addr_bits = ^{io_addr[31:8], io_addr[1:0]};

  assign in0_s       = sync0[SYNC_STAGES-1];
  assign in1_s       = sync1[SYNC_STAGES-1];
  assign timer_match = (timer == cmp);
  assign status_set  = {timer_match, |(in1_s ^ prev1), |(in0_s ^ prev0)};
  assign status_clr  = rd_en && (word == W_STATUS);
  assign io_irq      = |(status & irq_en);

  // Input synchronizer chains plus the one-cycle history used for change detect
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync0[i] <= '0;
        sync1[i] <= '0;
      end
      prev0 <= '0;
      prev1 <= '0;
    end else begin
      sync0[0] <= in_port0;
      sync1[0] <= in_port1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync0[i] <= sync0[i-1];
        sync1[i] <= sync1[i-1];
      end
      prev0 <= in0_s;
      prev1 <= in1_s;
    end
  end

  // Writable registers; a timer store replaces that cycle's increment
  always_ff @(posedge clock) begin
    if (reset) begin
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
      timer     <= '0;
      cmp       <= '1;
      irq_en    <= '0;
    end else begin
      if (wr_en && word == W_TIMER) timer <= io_wdata[TIMER_W-1:0];
      else                          timer <= timer + TIMER_W'(1);
      if (wr_en) begin
        case (word)
          W_OUT0:   out_port0 <= io_wdata;
          W_OUT1:   out_port1 <= io_wdata;
          W_OUT2:   out_port2 <= io_wdata;
          W_CMP:    cmp       <= io_wdata[TIMER_W-1:0];
          W_IRQ_EN: irq_en    <= io_wdata[2:0];
          default:  ;
        endcase
      end
    end
  end

  // Sticky status; a set condition in the clearing cycle keeps its bit
  always_ff @(posedge clock) begin
    if (reset) status <= '0;
    else       status <= (status_clr ? 3'b000 : status) | status_set;
  end

  // Read mux from current (pre-write, pre-clear) register values
  always_comb begin
    rd_mux = '0;
    case (word)
      W_OUT0:   rd_mux = out_port0;
      W_OUT1:   rd_mux = out_port1;
      W_OUT2:   rd_mux = out_port2;
      W_IN0:    rd_mux = in0_s;
      W_IN1:    rd_mux = in1_s;
      W_STATUS: rd_mux = {29'b0, status};
      W_TIMER:  rd_mux = 32'(timer);
      W_CMP:    rd_mux = 32'(cmp);
      W_IRQ_EN: rd_mux = {29'b0, irq_en};
      default:  rd_mux = '0;
    endcase
  end

  // Load response: data held until the next accepted read
  always_ff @(posedge clock) begin
    if (reset) begin
      io_read_data <= '0;
      io_rvalid    <= 1'b0;
    end else begin
      io_rvalid <= rd_en;
      if (rd_en) io_read_data <= rd_mux;
    end
  end

endmodule
